sw_debouncer: RTL and testbench

Input-side conditioner for the Atlys slide switches and push buttons. Synchronises up to WIDTH raw asynchronous inputs into the `clk` domain and debounces each bit independently. Emits a clean level, one-cycle rise and fall pulses, and a valid/ready change-event record for a downstream consumer such as an LED or counter controller. Sits between the board pins and any user logic that reads switches.

---
 rtl/sw_debouncer.sv | 93 +++++++++
 tb/tb_sw_debouncer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// sw_debouncer: two-flop synchroniser and independent per-bit debounce counters for board switches/buttons.
// Define SW_DEBOUNCER_EVENT_EN to build the valid/ready change-event record channel (evt_*).
module sw_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_ovf,
    input  logic             evt_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic             chg;

    // A bit's count only advances while the synchronised level disagrees with the accepted one.
    always_comb begin
        clean_nxt = sw_clean;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign chg = |(clean_nxt ^ sw_clean);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= sw_raw;
            s2       <= s1;
            sw_clean <= clean_nxt;
            sw_rise  <= clean_nxt & ~sw_clean;
            sw_fall  <= ~clean_nxt & sw_clean;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef SW_DEBOUNCER_EVENT_EN
    // A new change always wins the slot; overflow records whether an unaccepted record was lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_data  <= '0;
            evt_ovf   <= 1'b0;
        end else if (chg) begin
            evt_valid <= 1'b1;
            evt_data  <= clean_nxt;
            evt_ovf   <= evt_valid && !evt_ready;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
            evt_ovf   <= 1'b0;
        end
    end
`else
    logic unused_evt;

    assign unused_evt = evt_ready ^ chg;
    assign evt_valid  = 1'b0;
    assign evt_data   = '0;
    assign evt_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
// Self-checking bench for sw_debouncer: directed scenarios plus random switch activity against a queue-based model.
// Event expectations follow SW_DEBOUNCER_EVENT_EN exactly as the design does (all-zero when undefined).
module tb_sw_debouncer;

    localparam int W  = 8;
    localparam int DC = 4;
    localparam int CW = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         evt_valid;
    logic [W-1:0] evt_data;
    logic         evt_ovf;
    logic         evt_ready;

    int checks = 0;
    int errors = 0;

    sw_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .evt_ovf(evt_ovf),
        .evt_ready(evt_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DC synchronised samples all disagree with it.
    logic [W-1:0] m_clean, m_rise, m_fall, m_data;
    logic         m_valid, m_ovf;
    logic [W-1:0] raw_q[$];
    logic [W-1:0] s2_q[$];

    always @(posedge clk) begin : ref_model
        logic [W-1:0] s2v;
        logic [W-1:0] nc;
        bit           held;
        if (!rst_n) begin
            raw_q.delete();
            s2_q.delete();
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
        end else begin
            raw_q.push_front(sw_raw);
            if (raw_q.size() > 3) void'(raw_q.pop_back());
            s2v = (raw_q.size() == 3) ? raw_q[2] : '0;
            s2_q.push_front(s2v);
            if (s2_q.size() > DC) void'(s2_q.pop_back());
            nc = m_clean;
            if (s2_q.size() == DC) begin
                for (int b = 0; b < W; b++) begin
                    held = 1'b1;
                    for (int k = 0; k < DC; k++) begin
                        if (s2_q[k][b] == m_clean[b]) held = 1'b0;
                    end
                    if (held) nc[b] = ~m_clean[b];
                end
            end
            m_rise = nc & ~m_clean;
            m_fall = ~nc & m_clean;
`ifdef SW_DEBOUNCER_EVENT_EN
            if (nc != m_clean) begin
                m_ovf   = m_valid && !evt_ready;
                m_valid = 1'b1;
                m_data  = nc;
            end else if (m_valid && evt_ready) begin
                m_valid = 1'b0;
                m_ovf   = 1'b0;
            end
`endif
            m_clean = nc;
        end
    end

    logic [33:0] obs_vec, exp_vec;
    assign obs_vec = {sw_clean, sw_rise, sw_fall, evt_valid, evt_data, evt_ovf};
    assign exp_vec = {m_clean, m_rise, m_fall, m_valid, m_data, m_ovf};

    task automatic apply_reset(input int n);
        rst_n     = 1'b0;
        sw_raw    = '0;
        evt_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sw_raw    = 8'hFF;
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== 34'h0) begin
                errors++;
                $display("[TB] FAIL reset_zero cycle %0d: got %h expected 0", i, obs_vec);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL reset_release edge %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i == 5) begin
                checks++;
                if (sw_clean !== 8'h00) begin
                    errors++;
                    $display("[TB] FAIL reset_early edge 5: got clean=%h expected 00", sw_clean);
                end
            end
            if (i == 6) begin
                checks++;
                if (sw_clean !== 8'hFF || sw_rise !== 8'hFF) begin
                    errors++;
                    $display("[TB] FAIL reset_rise edge 6: got clean=%h rise=%h expected FF FF", sw_clean, sw_rise);
                end
`ifdef SW_DEBOUNCER_EVENT_EN
                checks++;
                if (evt_valid !== 1'b1 || evt_data !== 8'hFF) begin
                    errors++;
                    $display("[TB] FAIL reset_event edge 6: got v=%b d=%h expected 1 FF", evt_valid, evt_data);
                end
`endif
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset(2);
        for (int i = 0; i < 22; i++) begin
            sw_raw = (i < 3 || i >= 12) ? 8'h80 : 8'h00;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL glitch cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
            if (i == 11) begin
                checks++;
                if (sw_clean !== 8'h00 || evt_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL glitch_reject: got clean=%h v=%b expected 00 0", sw_clean, evt_valid);
                end
            end
        end
        checks++;
        if (sw_clean !== 8'h80) begin
            errors++;
            $display("[TB] FAIL glitch_accept: got clean=%h expected 80", sw_clean);
        end
    endtask

    task automatic test_independent();
        apply_reset(2);
        for (int i = 0; i < 14; i++) begin
            sw_raw = (i >= 2) ? 8'h09 : 8'h01;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL independent cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        checks++;
        if (sw_clean !== 8'h09) begin
            errors++;
            $display("[TB] FAIL independent_final: got clean=%h expected 09", sw_clean);
        end
    endtask

    task automatic test_overflow();
        apply_reset(2);
        for (int i = 0; i < 20; i++) begin
            sw_raw    = (i >= 8) ? 8'h03 : 8'h01;
            evt_ready = (i == 17);
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL overflow cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
`ifdef SW_DEBOUNCER_EVENT_EN
            if (i == 16) begin
                checks++;
                if (evt_data !== 8'h03 || evt_ovf !== 1'b1 || evt_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL overflow_flag: got v=%b d=%h o=%b expected 1 03 1", evt_valid, evt_data, evt_ovf);
                end
            end
            if (i == 17) begin
                checks++;
                if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL overflow_accept: got v=%b o=%b expected 0 0", evt_valid, evt_ovf);
                end
            end
`endif
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset(2);
        for (int i = 0; i < 10; i++) begin
            sw_raw = 8'h03;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL simul_setup cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            sw_raw    = 8'h07;
            evt_ready = (i == 6);
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL simul edge %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
`ifdef SW_DEBOUNCER_EVENT_EN
            if (i == 6) begin
                checks++;
                if (evt_valid !== 1'b1 || evt_data !== 8'h07 || evt_ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL simul_accept: got v=%b d=%h o=%b expected 1 07 0", evt_valid, evt_data, evt_ovf);
                end
            end
`endif
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset(2);
        for (int i = 0; i < 14; i++) begin
            sw_raw = (i >= 10) ? 8'h03 : 8'h01;
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL midreset_setup cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec !== 34'h0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got %h expected 0", obs_vec);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL midreset_release edge %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        checks++;
        if (sw_clean !== 8'h03) begin
            errors++;
            $display("[TB] FAIL midreset_final: got clean=%h expected 03", sw_clean);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] lvl;
        lvl = '0;
        apply_reset(2);
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
            end
            sw_raw    = lvl;
            evt_ready = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        rst_n     = 1'b1;
        evt_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_raw    = '0;
        evt_ready = 1'b0;
        test_reset();
        test_glitch();
        test_independent();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
